// File: rtl/adc_serial_cfg_pkg.sv
// Shared ADC package: serial-port word layout, ADS5282 register constants
// and the transmitter state encoding.
package adc_serial_cfg_pkg;

  localparam int ADC_CFG_W  = 24;
  localparam int ADC_ADDR_W = 8;
  localparam int ADC_DATA_W = 16;

  // ADS5282 software-reset register address
  localparam logic [ADC_ADDR_W-1:0] ADS_RST_ADDR = 8'h00;

  // IDLE must stay all-zero so the reset value of the state register is IDLE
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } cfg_state_e;

  function automatic logic [ADC_CFG_W-1:0] adc_cfg_pack(
    input logic [ADC_ADDR_W-1:0] addr,
    input logic [ADC_DATA_W-1:0] data
  );
    return {addr, data};
  endfunction

endpackage

// File: rtl/adc_serial_cfg_sclk_tick.sv
// SCLK half-period timer: down-counter that pulses tick once every CLK_DIV
// enabled cycles. Held at its load value while disabled or cleared, so the
// first half-period after enable is always a full CLK_DIV cycles long.
module adc_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;

  assign tick = en && !clr && (div_cnt == 8'd0);

  // Reload on terminal count, otherwise count down while enabled
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      div_cnt <= DIV_LD;
    end else if (clr || !en || div_cnt == 8'd0) begin
      div_cnt <= DIV_LD;
    end else begin
      div_cnt <= div_cnt - 8'd1;
    end
  end

endmodule

// File: rtl/adc_serial_cfg.sv
// ADS5282 serial-port transmitter: shifts one 24-bit {addr, data} word
// MSB-first on sen_n/sclk/sdata and answers with a one-cycle end_conf.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | sen_n high, waiting for start
// ST_SETUP | sen_n low, MSB on sdata, CS_SETUP cycles before first sclk rise
// ST_SHIFT | 24 sclk periods, sdata advances with each sclk rise
// ST_HOLD  | sen_n low, sclk low, CS_HOLD cycles after last sclk fall
// ST_DONE  | sen_n high, end_conf pulse, one cycle
//
// Pin outputs are registered from the current state, so they trail the
// state register by one cycle; abort bypasses that lag and idles the pins
// on the same edge it is sampled.
module adc_serial_cfg
  import adc_serial_cfg_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 start,
  input  logic [ADC_CFG_W-1:0] cfg_word,
  input  logic                 abort,
  output logic                 busy,
  output logic                 end_conf,
  output logic                 sen_n,
  output logic                 sclk,
  output logic                 sdata
);

  localparam logic [3:0] SETUP_LD = 4'(CS_SETUP - 1);
  localparam logic [3:0] HOLD_LD  = 4'(CS_HOLD - 1);
  localparam logic [4:0] LAST_BIT = 5'(ADC_CFG_W - 1);

  cfg_state_e           state_q;
  cfg_state_e           state_d;
  logic [ADC_CFG_W-1:0] shreg_q;
  logic [4:0]           bit_cnt_q;
  logic [3:0]           tmr_q;
  logic                 phase_hi_q;
  logic                 tick;
  logic                 tick_clr;
  logic                 tick_en;
  logic                 period_end;

  assign tick_clr   = (state_q == ST_IDLE) || abort;
  assign tick_en    = (state_q == ST_SHIFT);
  assign period_end = tick && !phase_hi_q;

  adc_sclk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_tick (
    .clk  (clk),
    .rstb (rstb),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  // State register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; abort overrides everything, including a start in IDLE
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_SETUP;
        ST_SETUP: if (tmr_q == 4'd0) state_d = ST_SHIFT;
        ST_SHIFT: if (period_end && bit_cnt_q == LAST_BIT) state_d = ST_HOLD;
        ST_HOLD:  if (tmr_q == 4'd0) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Shift register, bit counter, setup/hold timer and sclk phase
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      shreg_q    <= '0;
      bit_cnt_q  <= 5'd0;
      tmr_q      <= 4'd0;
      phase_hi_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            shreg_q   <= cfg_word;
            bit_cnt_q <= 5'd0;
            tmr_q     <= SETUP_LD;
          end
        end
        ST_SETUP: begin
          phase_hi_q <= 1'b1;
          if (tmr_q != 4'd0) tmr_q <= tmr_q - 4'd1;
        end
        ST_SHIFT: begin
          tmr_q <= HOLD_LD;
          if (tick) phase_hi_q <= ~phase_hi_q;
          if (period_end) begin
            shreg_q <= {shreg_q[ADC_CFG_W-2:0], 1'b0};
            if (bit_cnt_q != LAST_BIT) bit_cnt_q <= bit_cnt_q + 5'd1;
          end
        end
        ST_HOLD: begin
          if (tmr_q != 4'd0) tmr_q <= tmr_q - 4'd1;
        end
        default: begin
          phase_hi_q <= 1'b0;
        end
      endcase
    end
  end

  // Registered pin and handshake outputs, decoded from the current state
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sen_n    <= 1'b1;
      sclk     <= 1'b0;
      sdata    <= 1'b0;
      busy     <= 1'b0;
      end_conf <= 1'b0;
    end else if (abort) begin
      sen_n    <= 1'b1;
      sclk     <= 1'b0;
      sdata    <= 1'b0;
      busy     <= 1'b0;
      end_conf <= 1'b0;
    end else begin
      case (state_q)
        ST_SETUP, ST_HOLD: begin
          sen_n    <= 1'b0;
          sclk     <= 1'b0;
          sdata    <= shreg_q[ADC_CFG_W-1];
          busy     <= 1'b1;
          end_conf <= 1'b0;
        end
        ST_SHIFT: begin
          sen_n    <= 1'b0;
          sclk     <= phase_hi_q;
          sdata    <= shreg_q[ADC_CFG_W-1];
          busy     <= 1'b1;
          end_conf <= 1'b0;
        end
        ST_DONE: begin
          sen_n    <= 1'b1;
          sclk     <= 1'b0;
          sdata    <= 1'b0;
          busy     <= 1'b1;
          end_conf <= 1'b1;
        end
        default: begin
          sen_n    <= 1'b1;
          sclk     <= 1'b0;
          sdata    <= 1'b0;
          busy     <= 1'b0;
          end_conf <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/adc_serial_cfg.md
# adc_serial_cfg

Serial-port transmitter that writes one configuration word into the ADS5282 ADC register bank. It is the responder to the automatic-configuration sequencer: it accepts a one-cycle start strobe plus a 24-bit word (8-bit address, 16-bit data), and shifts the word MSB-first on SEN/SCLK/SDATA. It then returns a one-cycle `end_conf` pulse so the sequencer can advance to the next register. It sits between the configuration register table and the ADC pins.

## Interface
Parameters:
- `CLK_DIV`, 4 — clk cycles per SCLK half-period; legal range 2..255.
- `CS_SETUP`, 2 — clk cycles from SEN falling to the first SCLK rising edge; legal range 1..15.
- `CS_HOLD`, 2 — clk cycles from the last SCLK falling edge to SEN rising; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rstb`  in  1  reset. Asynchronous, active-low.
- `start`  in  1  one-cycle request, driven from the sequencer's `init_auto`.
- `cfg_word`  in  24  word to send, {addr[7:0], data[15:0]}. Sampled only on an accepted `start`.
- `abort`  in  1  synchronous cancel, driven from `adc_rst`.
- `busy`  out  1  high in every state except IDLE.
- `end_conf`  out  1  one-cycle pulse when a word has been fully sent.
- `sen_n`  out  1  ADC serial enable, active-low.
- `sclk`  out  1  ADC serial clock.
- `sdata`  out  1  ADC serial data.

## Operation
- All outputs are registered.
- Reset values: `sen_n`=1, `sclk`=0, `sdata`=0, `busy`=0, `end_conf`=0, state=IDLE.
- **IDLE**
  - Idle outputs as at reset.
  - `start`=1 and `abort`=0: latch `cfg_word` into a shift register, clear the bit counter, go to SETUP.
- **SETUP**
  - `sen_n`=0, `sclk`=0, `sdata`=word[23].
  - Lasts `CS_SETUP` cycles, then go to SHIFT.
- **SHIFT**
  - 24 bit periods of 2·`CLK_DIV` cycles each.
  - Each period: `sclk`=1 for `CLK_DIV` cycles, then `sclk`=0 for `CLK_DIV` cycles.
  - The ADC samples `sdata` on the SCLK falling edge.
  - `sdata` advances to the next bit on the same clk edge that raises `sclk`, except for bit 23, which is presented at SETUP entry.
  - So `sdata` is stable for `CLK_DIV` cycles before each falling edge.
  - The 5-bit counter counts 0..23. After the low half of bit 0 (the LSB), go to HOLD.
- **HOLD**
  - `sen_n`=0, `sclk`=0.
  - Lasts `CS_HOLD` cycles, then go to DONE.
- **DONE**
  - `sen_n`=1, `end_conf`=1, `busy`=1, for exactly one cycle; then go to IDLE.
- Boundary rules:
  - `start` in any non-IDLE state is ignored; no queueing.
  - `abort`=1 in any state: next state is IDLE with idle outputs, and no `end_conf` is issued.
  - `abort` and `start` together in IDLE: `abort` wins and the start is dropped.
  - `rstb` low mid-word forces the reset values immediately (asynchronously). The partial word is discarded.
  - `cfg_word` changing after acceptance has no effect on the word being sent.

## Timing
- Let `start` be sampled at edge E0.
  - `sen_n` falls at E0+1.
  - First `sclk` rise at E0+1+`CS_SETUP`.
  - `end_conf` is high during cycle E0+N, with N = 1 + `CS_SETUP` + 48·`CLK_DIV` + `CS_HOLD`. Defaults give N = 197.
- SCLK frequency = f_clk / (2·`CLK_DIV`). At 100 MHz with the default, that is 12.5 MHz, within the ADS5282's 20 MHz limit.
- Minimum SEN-high time between words: 1 cycle in DONE plus 1 in IDLE. The sequencer's 2-cycle turnaround (end_conf → incr → init_auto) meets this.
- Word throughput: one word per N+1 cycles or longer.

## Structure
- Shared ADC package holds:
  - `ADC_CFG_W`=24, `ADC_ADDR_W`=8, `ADC_DATA_W`=16;
  - the state encoding, with IDLE = all-zero;
  - the ADS5282 reset-register address 8'h00.
- One natural sub-module, `adc_sclk_tick`:
  - the divide-by-`CLK_DIV` counter;
  - emits half-period ticks;
  - cleared on IDLE and `abort`.
- The FSM, shift register, bit counter and setup/hold counter stay in `adc_serial_cfg`.

## Test plan
- **Single word:** reset, `start` with `cfg_word`=24'h42_A5C3, defaults → `sen_n` low for exactly 2+192+2 cycles. A bench model sampling on SCLK falling edges reads 24'h42A5C3. `end_conf` is high only at E0+197. `busy` falls at E0+198.
- **Back-to-back sequence:** drive 8 words, each with `start` 2 cycles after the previous `end_conf` → 8 `end_conf` pulses, each word decoded intact, `sen_n` high ≥2 cycles between words.
- **Start while busy:** a second `start` with 24'hFFFFFF at E0+50 → ignored. The decoded word is still the first one, and only one `end_conf` is issued.
- **Abort mid-shift:** `abort` at E0+100 → next cycle `sen_n`=1, `sclk`=0, `busy`=0. No `end_conf`. A later `start` completes normally.
- **Async reset mid-word:** `rstb` low at E0+60 → all outputs return to reset values without waiting for a clk edge.
- **Parameter sweep:** `CLK_DIV`=2, `CS_SETUP`=1, `CS_HOLD`=1 → `end_conf` at E0+99, and SCLK high and low phases are each exactly 2 cycles.
